// File: rtl/lcd_responder.sv
// HD44780-style display responder: samples the 8-bit LCD bus on lcd_en falls and keeps an 80-byte DDRAM mirror.
// Optional busy timing is enabled by LCD_RESPONDER_BUSY_CHECK_EN; without it only the clear/fill makes the block busy.
module lcd_responder #(
    parameter int BUSY_CYC = 1850,
    parameter int CLR_CYC  = 76000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_en,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       display_on,
    output logic       two_line,
    output logic [6:0] cursor_addr,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic       timing_err,
    output logic       addr_err
);

    typedef enum logic [1:0] {S_FILL, S_IDLE, S_BUSY} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_en_s1, r_en_s2, r_en_s3, r_rs_s1, r_rs_s2;
    logic [7:0] r_data_s1, r_data_s2;
    logic [6:0] r_fill_idx, r_cursor;
    logic       r_id, r_two_line, r_display_on;
    logic       r_cmd_stb, r_data_stb, r_timing_err, r_addr_err;
    logic [7:0] r_mem [0:79];
    logic [7:0] r_rd_char;

    // Returns {mapped, index}: two-line folds 0x40-0x67 onto indices 40-79.
    function automatic logic [7:0] f_map(input logic [6:0] a, input logic two);
        if (two) begin
            if (a <= 7'h27)                 return {1'b1, a};
            else if (a >= 7'h40 && a <= 7'h67) return {1'b1, a - 7'd24};
            else                            return 8'h00;
        end
        if (a <= 7'h4F) return {1'b1, a};
        return 8'h00;
    endfunction

    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == 7'h27)       r = 7'h40;
            else if (inc && a == 7'h67)  r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h67;
            else if (!inc && a == 7'h40) r = 7'h27;
        end else begin
            if (inc && a == 7'h4F)       r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h4F;
        end
        return r;
    endfunction

    logic       w_fall, w_accept, w_terr, w_clear, w_we;
    logic [7:0] w_cur_map, w_set_map, w_rd_map, w_wdat;
    logic [6:0] w_widx;

    assign w_fall    = r_en_s3 & ~r_en_s2;
    assign w_accept  = w_fall && (r_state == S_IDLE);
    assign w_terr    = w_fall && (r_state != S_IDLE);
    assign w_clear   = w_accept && !r_rs_s2 && (r_data_s2 == 8'h01);
    assign w_cur_map = f_map(r_cursor, r_two_line);
    assign w_set_map = f_map(r_data_s2[6:0], r_two_line);
    assign w_rd_map  = f_map(rd_addr, r_two_line);

`ifdef LCD_RESPONDER_BUSY_CHECK_EN
    localparam int CNT_MAX = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_home;
    assign w_home = w_accept && !r_rs_s2 && (r_data_s2[7:1] == 7'b0000001);

    // The counter also runs during the fill, so the 80 fill cycles come out of CLR_CYC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                   r_cnt <= '0;
        else if (w_accept)                              r_cnt <= (w_clear || w_home) ? CNT_W'(CLR_CYC) : CNT_W'(BUSY_CYC);
        else if (r_state != S_IDLE && r_cnt != '0)      r_cnt <= r_cnt - 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FILL;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: if (r_fill_idx == 7'd79) begin
`ifdef LCD_RESPONDER_BUSY_CHECK_EN
                w_state_nxt = (r_cnt > CNT_W'(1)) ? S_BUSY : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (w_clear) w_state_nxt = S_FILL;
`ifdef LCD_RESPONDER_BUSY_CHECK_EN
                else if (w_accept) w_state_nxt = S_BUSY;
`endif
            end
`ifdef LCD_RESPONDER_BUSY_CHECK_EN
            S_BUSY: if (r_cnt <= CNT_W'(1)) w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef LCD_RESPONDER_BUSY_CHECK_EN
        busy = (r_state != S_IDLE);
`else
        busy = (r_state == S_FILL);
`endif
        w_we   = 1'b0;
        w_widx = r_fill_idx;
        w_wdat = 8'h20;
        if (r_state == S_FILL) begin
            w_we = 1'b1;
        end else if (w_accept && r_rs_s2 && w_cur_map[7]) begin
            w_we   = 1'b1;
            w_widx = w_cur_map[6:0];
            w_wdat = r_data_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_en_s1, r_en_s2, r_en_s3, r_rs_s1, r_rs_s2} <= '0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_en_s1   <= lcd_en;
            r_en_s2   <= r_en_s1;
            r_en_s3   <= r_en_s2;
            r_rs_s1   <= lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_data_s1 <= lcd_data;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_idx   <= '0;
            r_cursor     <= '0;
            r_id         <= 1'b1;
            r_two_line   <= 1'b0;
            r_display_on <= 1'b0;
            r_cmd_stb    <= 1'b0;
            r_data_stb   <= 1'b0;
            r_timing_err <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_cmd_stb    <= w_accept && !r_rs_s2;
            r_data_stb   <= w_accept && r_rs_s2;
            r_timing_err <= w_terr;
            r_addr_err   <= 1'b0;
            if (w_clear)                                        r_fill_idx <= '0;
            else if (r_state == S_FILL && r_fill_idx != 7'd79)  r_fill_idx <= r_fill_idx + 7'd1;
            if (w_accept && r_rs_s2) begin
                r_cursor <= f_step(r_cursor, r_id, r_two_line);
            end else if (w_accept) begin
                casez (r_data_s2)
                    8'b1???????: if (w_set_map[7]) r_cursor <= r_data_s2[6:0];
                                 else              r_addr_err <= 1'b1;
                    8'b01??????: ;
                    8'b001?????: r_two_line <= r_data_s2[3];
                    8'b0001????: if (!r_data_s2[3]) r_cursor <= f_step(r_cursor, r_data_s2[2], r_two_line);
                    8'b00001???: r_display_on <= r_data_s2[2];
                    8'b000001??: r_id <= r_data_s2[1];
                    8'b0000001?: r_cursor <= '0;
                    8'b00000001: begin
                        r_cursor <= '0;
                        r_id     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_wdat;
    end

    // Registered read sees the pre-write byte when the same index is written this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rd_char <= 8'h00;
        else          r_rd_char <= w_rd_map[7] ? r_mem[w_rd_map[6:0]] : 8'h20;
    end

    assign rd_char     = r_rd_char;
    assign display_on  = r_display_on;
    assign two_line    = r_two_line;
    assign cursor_addr = r_cursor;
    assign cmd_strobe  = r_cmd_stb;
    assign data_strobe = r_data_stb;
    assign timing_err  = r_timing_err;
    assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: instruction/data table with a strobe scoreboard, plus fill, latency, error and reset sequences.
module tb_lcd_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;
    logic       busy, display_on, two_line, cmd_strobe, data_strobe, timing_err, addr_err;
    logic [6:0] cursor_addr;

    lcd_responder #(.BUSY_CYC(20), .CLR_CYC(200)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
        .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy), .display_on(display_on),
        .two_line(two_line), .cursor_addr(cursor_addr), .cmd_strobe(cmd_strobe),
        .data_strobe(data_strobe), .timing_err(timing_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic is_data; logic [6:0] cur; } exp_t;
    typedef struct { logic rs; logic [7:0] d; logic [6:0] cur; logic two; logic disp; } vec_t;

    exp_t sb_q [$];
    exp_t sb_e;
    vec_t tbl  [$];
    int   n_chk = 0, n_err = 0, n_stb = 0, n_terr = 0, n_aerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every accepted transfer must appear as exactly one strobe of the right kind with the right cursor.
    always @(negedge clk) begin
        if (cmd_strobe || data_strobe) begin
            n_stb++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: strobe with empty queue, cursor 0x%0h", cursor_addr);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_kind", {31'd0, data_strobe}, {31'd0, sb_e.is_data});
                chk("sb_cursor", {25'd0, cursor_addr}, {25'd0, sb_e.cur});
            end
        end
        if (timing_err) n_terr++;
        if (addr_err)   n_aerr++;
    end

    task automatic send(input logic rs, input logic [7:0] d, input logic acc, input logic [6:0] cur);
        @(posedge clk); #1;
        lcd_rs   = rs;
        lcd_data = d;
        if (acc) sb_q.push_back({rs, cur});
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk) rd_addr = a;
        @(posedge clk); #1;
        chk(nm, {24'd0, rd_char}, {24'd0, exp});
    endtask

    task automatic busy_count(input string nm);
        int n;
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk(nm, n, 80);
    endtask

    initial begin
        int t0, a0;
        reset_n  = 1'b0;
        lcd_en   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 7'h00;

        tbl.push_back('{0, 8'h38, 7'h00, 1, 0});
        tbl.push_back('{0, 8'h0C, 7'h00, 1, 1});
        tbl.push_back('{0, 8'h01, 7'h00, 1, 1});
        tbl.push_back('{0, 8'h06, 7'h00, 1, 1});
        tbl.push_back('{0, 8'h80, 7'h00, 1, 1});
        tbl.push_back('{1, "A",   7'h01, 1, 1});
        tbl.push_back('{1, "B",   7'h02, 1, 1});
        tbl.push_back('{0, 8'hA7, 7'h27, 1, 1});
        tbl.push_back('{1, "X",   7'h40, 1, 1});
        tbl.push_back('{1, "Y",   7'h41, 1, 1});
        tbl.push_back('{0, 8'h04, 7'h41, 1, 1});
        tbl.push_back('{0, 8'h80, 7'h00, 1, 1});
        tbl.push_back('{1, "Z",   7'h67, 1, 1});
        tbl.push_back('{0, 8'h10, 7'h66, 1, 1});
        tbl.push_back('{0, 8'h14, 7'h67, 1, 1});
        tbl.push_back('{0, 8'h1C, 7'h67, 1, 1});
        tbl.push_back('{0, 8'h02, 7'h00, 1, 1});
        tbl.push_back('{0, 8'h30, 7'h00, 0, 1});
        tbl.push_back('{0, 8'hCF, 7'h4F, 0, 1});
        tbl.push_back('{0, 8'h06, 7'h4F, 0, 1});
        tbl.push_back('{1, "Q",   7'h00, 0, 1});
        tbl.push_back('{0, 8'h08, 7'h00, 0, 0});

        // Reset values, then the power-on fill.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_display_on", {31'd0, display_on}, 32'd0);
        chk("rst_two_line", {31'd0, two_line}, 32'd0);
        chk("rst_cursor", {25'd0, cursor_addr}, 32'd0);
        chk("rst_rd_char", {24'd0, rd_char}, 32'd0);
        chk("rst_strobes", {30'd0, cmd_strobe, data_strobe}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        busy_count("fill_busy_cycles");
        for (int a = 0; a < 80; a++) rd_chk("fill_blank", 7'(a), 8'h20);

        // Instruction/data table.
        a0 = n_stb;
        foreach (tbl[i]) begin
            send(tbl[i].rs, tbl[i].d, 1'b1, tbl[i].cur);
            wait_idle("tbl");
            chk($sformatf("tbl%0d_two_line", i), {31'd0, two_line}, {31'd0, tbl[i].two});
            chk($sformatf("tbl%0d_display_on", i), {31'd0, display_on}, {31'd0, tbl[i].disp});
        end
        chk("tbl_strobe_total", n_stb - a0, 22);

        // One-line read map.
        rd_chk("rd1_00", 7'h00, "Z");
        rd_chk("rd1_01", 7'h01, "B");
        rd_chk("rd1_02", 7'h02, 8'h20);
        rd_chk("rd1_27", 7'h27, "X");
        rd_chk("rd1_28", 7'h28, "Y");
        rd_chk("rd1_4F", 7'h4F, "Q");
        rd_chk("rd1_unmapped", 7'h50, 8'h20);

        // Unmapped Set DDRAM in two-line mode.
        a0 = n_aerr;
        send(0, 8'h38, 1'b1, 7'h00);
        send(0, 8'hB0, 1'b1, 7'h00);
        wait_idle("aerr");
        chk("addr_err_pulses", n_aerr - a0, 1);
        chk("addr_err_cursor", {25'd0, cursor_addr}, 32'd0);
        rd_chk("rd2_40", 7'h40, "Y");
        rd_chk("rd2_27", 7'h27, "X");
        rd_chk("rd2_67", 7'h67, "Q");
        rd_chk("rd2_unmapped", 7'h30, 8'h20);

        // A transfer falling during the clear fill is discarded.
        t0 = n_terr;
        send(0, 8'h01, 1'b1, 7'h00);
        send(1, "K", 1'b0, 7'h00);
        wait_idle("terr_fill");
        chk("terr_fill_pulses", n_terr - t0, 1);
        chk("terr_fill_cursor", {25'd0, cursor_addr}, 32'd0);
        rd_chk("terr_fill_mem", 7'h00, 8'h20);

        // Strobe appears on the 3rd edge after lcd_en is first sampled low.
        @(posedge clk); #1;
        lcd_rs = 1'b1; lcd_data = "L"; lcd_en = 1'b1;
        sb_q.push_back({1'b1, 7'h01});
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_edge2_strobe", {31'd0, data_strobe}, 32'd0);
        chk("lat_edge2_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("lat_edge3_strobe", {31'd0, data_strobe}, 32'd1);
`ifdef LCD_RESPONDER_BUSY_CHECK_EN
        begin
            int n;
            n = 0;
            repeat (100) begin
                if (busy) n++;
                else break;
                @(negedge clk);
            end
            chk("busy_cycles_data", n, 20);
        end
`else
        chk("lat_edge3_busy", {31'd0, busy}, 32'd0);
`endif
        repeat (4) @(posedge clk);
        rd_chk("lat_mem", 7'h00, "L");

`ifdef LCD_RESPONDER_BUSY_CHECK_EN
        // Second write 10 clk after the first lands inside the busy window.
        t0 = n_terr;
        @(posedge clk); #1;
        lcd_rs = 1'b1; lcd_data = "M"; lcd_en = 1'b1;
        sb_q.push_back({1'b1, 7'h02});
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 lcd_data = "N"; lcd_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
        wait_idle("pair10");
        chk("pair10_terr", n_terr - t0, 1);
        rd_chk("pair10_first", 7'h01, "M");
        rd_chk("pair10_second", 7'h02, 8'h20);

        // 30 clk apart: both writes land.
        t0 = n_terr;
        @(posedge clk); #1;
        lcd_data = "P"; lcd_en = 1'b1;
        sb_q.push_back({1'b1, 7'h03});
        repeat (4) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (25) @(posedge clk);
        #1 lcd_data = "R"; lcd_en = 1'b1;
        sb_q.push_back({1'b1, 7'h04});
        repeat (5) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
        wait_idle("pair30");
        chk("pair30_terr", n_terr - t0, 0);
        rd_chk("pair30_first", 7'h02, "P");
        rd_chk("pair30_second", 7'h03, "R");
`endif

        // Reset partway through a clear fill restarts the whole fill.
        send(0, 8'h01, 1'b1, 7'h00);
        repeat (37) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midfill_rst_busy", {31'd0, busy}, 32'd1);
        chk("midfill_rst_two_line", {31'd0, two_line}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        busy_count("midfill_busy_cycles");
        chk("midfill_cursor", {25'd0, cursor_addr}, 32'd0);
        chk("midfill_display_on", {31'd0, display_on}, 32'd0);
        rd_chk("midfill_mem", 7'h00, 8'h20);

        repeat (4) @(posedge clk);
        chk("sb_leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

HD44780-compatible character-LCD responder: the display end of the 8-bit, write-only LCD bus driven by the team's LCD controller. It samples `lcd_data`/`lcd_rs` on each falling edge of `lcd_en`, decodes instructions, and maintains an 80-byte DDRAM image, cursor address and display flags. The image is exposed on a registered read port. It serves as an on-chip display mirror (debug/UART dump) and as the checker-side model in system benches.

## Interface
- `BUSY_CYC`, 1850: busy time after a normal instruction or data write, in clk cycles (37 µs at 50 MHz).
- `CLR_CYC`, 76000: busy time after Clear (0x01) or Return Home (0x02/0x03), in clk cycles (1.52 ms); must be ≥ 80.
- `clk`  in  1  system clock (50 MHz nominal).
- `reset_n`  in  1  asynchronous, active-low reset.
- `lcd_data`  in  8  LCD data bus (asynchronous to clk).
- `lcd_rs`  in  1  0 = instruction, 1 = data (asynchronous).
- `lcd_en`  in  1  enable strobe; falling edge latches the transfer (asynchronous).
- `rd_addr`  in  7  DDRAM read address, HD44780 address map.
- `rd_char`  out  8  DDRAM byte at `rd_addr`, one-cycle latency.
- `busy`  out  1  responder busy (fill or instruction time).
- `display_on`  out  1  D bit from Display Control.
- `two_line`  out  1  N bit from Function Set.
- `cursor_addr`  out  7  current DDRAM address counter.
- `cmd_strobe`  out  1  one-cycle pulse per accepted instruction.
- `data_strobe`  out  1  one-cycle pulse per accepted data write.
- `timing_err`  out  1  one-cycle pulse when a transfer arrives while busy (transfer discarded).
- `addr_err`  out  1  one-cycle pulse on Set DDRAM to an unmapped address.

## Operation
- Input path: `lcd_en`, `lcd_rs` and `lcd_data` each pass through a 2-flop synchronizer, plus a third `lcd_en` flop. A fall is detected when the third flop is 1 and the second is 0; rs/data are taken from the second stage.
- FSM states:
  - S_FILL: writes 0x20 to DDRAM index 0..79, one per cycle, then enters S_BUSY if time remains on the counter, otherwise S_IDLE.
  - S_IDLE: accepts a fall.
  - S_BUSY: counts down to 0, then returns to S_IDLE.
- Memory index mapping:
  - Two-line mode: addr 0x00–0x27 maps to index 0–39; addr 0x40–0x67 maps to index 40–79.
  - One-line mode: addr 0x00–0x4F maps to index 0–79.
  - Other addresses are unmapped.
- Data write (rs=1): the byte goes to DDRAM[cursor], then the cursor steps by I/D (+1 or −1).
  - Two-line wrap: 0x27→0x40, 0x67→0x00, 0x00→0x67 (on decrement), 0x40→0x27 (on decrement).
  - One-line wrap: 0x4F↔0x00.
- Instruction decode (rs=0), priority by highest set bit:
  - 1xxxxxxx: Set DDRAM to `data[6:0]`. If the address is unmapped in the current mode, `addr_err` pulses and the cursor is unchanged.
  - 01xxxxxx: Set CGRAM, accepted but no state change.
  - 001xxxxx: Function Set; N goes to `two_line`. DL and F are ignored; the bus is always 8-bit.
  - 0001xxxx: Shift. With S/C=0 the cursor moves by R/L using the wrap rules; with S/C=1 the instruction is a no-op.
  - 00001xxx: Display Control; D goes to `display_on`. C and B are ignored.
  - 000001xx: Entry Mode; I/D is latched. S is ignored.
  - 0000001x: Return Home; cursor = 0.
  - 00000001: Clear; cursor = 0, I/D = 1, enters S_FILL.
  - 0x00: no-op, still counts as accepted.
- Busy:
  - Every accepted transfer loads the busy counter with `BUSY_CYC`, or `CLR_CYC` for Clear/Home, and enters S_BUSY (or S_FILL for Clear).
  - A fall arriving outside S_IDLE is discarded and `timing_err` pulses.
- Reset values:
  - State S_FILL with fill index 0; busy counter 0.
  - `busy`=1, `display_on`=0, `two_line`=0, I/D=1, `cursor_addr`=0, `rd_char`=0x00, all strobes and error pulses 0.
- Read port: `rd_char` ← DDRAM[map(`rd_addr`)]. An unmapped `rd_addr` returns 0x20. Reads are live during a fill and return the partially cleared contents.

## Timing
- A transfer takes effect (DDRAM/cursor/flag update plus strobe) on the 3rd rising clk edge, counting the first edge that samples `lcd_en` low.
- `lcd_rs`/`lcd_data` must be stable from ≥3 clk before to ≥3 clk after the `lcd_en` fall.
- `busy` rises on the same edge as the strobe and stays high for exactly the loaded count. Clear: 80 fill cycles are included in `CLR_CYC`.
- `rd_char` is valid one clk after `rd_addr` is presented. A write and a read to the same index in the same cycle return the old byte.
- `reset_n` asserted mid-fill or mid-busy aborts the operation immediately; the fill restarts from index 0 on release.

## Configuration
- `LCD_RESPONDER_BUSY_CHECK_EN` defined: the busy counter and S_BUSY are implemented as above.
- `LCD_RESPONDER_BUSY_CHECK_EN` undefined:
  - No counter; the parameters are unused.
  - `busy` is high only during S_FILL, and S_FILL returns straight to S_IDLE.
  - `timing_err` fires only for falls during S_FILL.

## Test plan
- Reset, macro off → `busy`=1 for 80 cycles, then 0; all rd_addr 0x00–0x4F read 0x20; `display_on`=0, `two_line`=0, `cursor_addr`=0.
- 0x38, 0x0C, 0x01, 0x06, 0x80, 'A', 'B', sent at 2 ms spacing → `two_line`=1, `display_on`=1; rd 0x00='A', 0x01='B'; `cursor_addr`=0x02; 7 strobes total.
- Two-line mode: 0xA7, then 'X', 'Y' → 'X' at 0x27, 'Y' at 0x40, `cursor_addr`=0x41.
- 0x04, 0x80, 'Z' → 'Z' at 0x00, `cursor_addr`=0x67. Then 0x10 → cursor 0x66.
- Macro on, BUSY_CYC=20: two data writes 10 clk apart → second discarded, one `timing_err` pulse, DDRAM unchanged. Repeat at 30 clk apart → both written.
- Two-line mode, 0xB0 → `addr_err` pulse, cursor unchanged. `reset_n` low at fill index 40 → fill restarts, `busy` high for a further 80 cycles.
